gps_ack_sched: RTL and testbench

Search scheduler that sequences the GPS acquisition correlator over a range of satellites and a grid of Doppler bins. For each PRN it issues one correlation per Doppler bin, waits for completion and keeps the strongest peak. It then reports one result per satellite over a valid/ready handshake. It sits between the acquisition control/CPU interface and the correlator, and is the only master of the correlator's start/sat/doppler inputs.

---
 rtl/gps_ack_sched.sv | 211 +++++++++++++++++++++
 tb/tb_gps_ack_sched.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_ack_sched.sv
// Acquisition search scheduler: sweeps a PRN range over a Doppler grid on the
// correlator, keeps the strongest peak per PRN and reports it over valid/ready.
module gps_ack_sched #(
    parameter logic signed [15:0] DOPPLER_INIT = -16'sd80,
    parameter int                 DOPPLER_STEP = 4,
    parameter int                 DOPPLER_NUM  = 40,
    parameter int                 WDOG_CYCLES  = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               search_start,
    input  logic               abort,
    input  logic [5:0]         sat_first,
    input  logic [5:0]         sat_last,
    input  logic [13:0]        threshold,
    output logic               busy,
    output logic               search_done,
    output logic               corr_start,
    output logic [5:0]         corr_sat,
    output logic signed [15:0] corr_doppler,
    input  logic               corr_done,
    input  logic [9:0]         corr_code_phase,
    input  logic [13:0]        corr_mag,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [5:0]         res_sat,
    output logic [9:0]         res_code_phase,
    output logic signed [15:0] res_doppler,
    output logic [13:0]        res_mag,
    output logic               res_found,
    output logic               res_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_REPORT
    } state_t;

    localparam logic [15:0]        BIN_LAST = 16'(DOPPLER_NUM - 1);
    localparam logic signed [15:0] DOP_STEP = 16'(DOPPLER_STEP);
    localparam logic [31:0]        WDOG_LIM = 32'(WDOG_CYCLES);
    localparam bit                 WDOG_EN  = (WDOG_CYCLES != 0);

    state_t             r_state;
    logic               r_busy;
    logic               r_search_done;
    logic               r_corr_start;
    logic [5:0]         r_corr_sat;
    logic [5:0]         r_sat_last;
    logic signed [15:0] r_corr_doppler;
    logic [15:0]        r_bin;
    logic [31:0]        r_wdog;
    logic [13:0]        r_best_mag;
    logic [9:0]         r_best_cp;
    logic signed [15:0] r_best_dop;
    logic               r_tmo;
    logic               r_res_valid;
    logic [5:0]         r_res_sat;
    logic [9:0]         r_res_cp;
    logic signed [15:0] r_res_dop;
    logic [13:0]        r_res_mag;
    logic               r_res_tmo;

    logic               w_in_wait;
    logic               w_wdog_hit;
    logic               w_tmo_bin;
    logic               w_bin_done;
    logic               w_upd;
    logic               w_tmo;
    logic               w_range_bad;
    logic [13:0]        w_best_mag;
    logic [9:0]         w_best_cp;
    logic signed [15:0] w_best_dop;

    assign w_in_wait   = (r_state == S_WAIT);
    assign w_wdog_hit  = WDOG_EN && (r_wdog == WDOG_LIM);
    // A real completion wins over a watchdog expiry in the same cycle.
    assign w_tmo_bin   = w_in_wait && !corr_done && w_wdog_hit;
    assign w_bin_done  = w_in_wait && (corr_done || w_wdog_hit);
    assign w_upd       = w_in_wait && corr_done && (corr_mag > r_best_mag);
    assign w_tmo       = r_tmo | w_tmo_bin;
    assign w_range_bad = (sat_first > sat_last) || (sat_first == 6'd0);

    assign w_best_mag  = w_upd ? corr_mag        : r_best_mag;
    assign w_best_cp   = w_upd ? corr_code_phase : r_best_cp;
    assign w_best_dop  = w_upd ? r_corr_doppler  : r_best_dop;

    assign busy           = r_busy;
    assign search_done    = r_search_done;
    assign corr_start     = r_corr_start;
    assign corr_sat       = r_corr_sat;
    assign corr_doppler   = r_corr_doppler;
    assign res_valid      = r_res_valid;
    assign res_sat        = r_res_sat;
    assign res_code_phase = r_res_cp;
    assign res_doppler    = r_res_dop;
    assign res_mag        = r_res_mag;
    assign res_timeout    = r_res_tmo;
    // Threshold is compared live so software may retune while a result waits.
    assign res_found      = r_res_valid && (r_res_mag >= threshold);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_search_done  <= 1'b0;
            r_corr_start   <= 1'b0;
            r_corr_sat     <= 6'd0;
            r_sat_last     <= 6'd0;
            r_corr_doppler <= DOPPLER_INIT;
            r_bin          <= 16'd0;
            r_wdog         <= 32'd0;
            r_best_mag     <= 14'd0;
            r_best_cp      <= 10'd0;
            r_best_dop     <= 16'sd0;
            r_tmo          <= 1'b0;
            r_res_valid    <= 1'b0;
            r_res_sat      <= 6'd0;
            r_res_cp       <= 10'd0;
            r_res_dop      <= 16'sd0;
            r_res_mag      <= 14'd0;
            r_res_tmo      <= 1'b0;
        end else if (abort) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_corr_start  <= 1'b0;
            r_search_done <= 1'b0;
        end else begin
            r_search_done <= 1'b0;
            r_corr_start  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (search_start) begin
                        r_sat_last <= sat_last;
                        if (w_range_bad) begin
                            r_search_done <= 1'b1;
                        end else begin
                            r_corr_sat     <= sat_first;
                            r_corr_doppler <= DOPPLER_INIT;
                            r_bin          <= 16'd0;
                            r_best_mag     <= 14'd0;
                            r_best_cp      <= 10'd0;
                            r_best_dop     <= 16'sd0;
                            r_tmo          <= 1'b0;
                            r_busy         <= 1'b1;
                            r_corr_start   <= 1'b1;
                            r_state        <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    r_wdog  <= 32'd0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    r_best_mag <= w_best_mag;
                    r_best_cp  <= w_best_cp;
                    r_best_dop <= w_best_dop;
                    r_tmo      <= w_tmo;
                    if (w_bin_done) begin
                        if (r_bin == BIN_LAST) begin
                            r_res_valid <= 1'b1;
                            r_res_sat   <= r_corr_sat;
                            r_res_cp    <= w_best_cp;
                            r_res_dop   <= w_best_dop;
                            r_res_mag   <= w_best_mag;
                            r_res_tmo   <= w_tmo;
                            r_state     <= S_REPORT;
                        end else begin
                            r_bin          <= r_bin + 16'd1;
                            r_corr_doppler <= r_corr_doppler + DOP_STEP;
                            r_corr_start   <= 1'b1;
                            r_state        <= S_ISSUE;
                        end
                    end else if (WDOG_EN) begin
                        r_wdog <= r_wdog + 32'd1;
                    end
                end

                S_REPORT: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_corr_sat == r_sat_last) begin
                            r_search_done <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_corr_sat     <= r_corr_sat + 6'd1;
                            r_corr_doppler <= DOPPLER_INIT;
                            r_bin          <= 16'd0;
                            r_best_mag     <= 14'd0;
                            r_best_cp      <= 10'd0;
                            r_best_dop     <= 16'sd0;
                            r_tmo          <= 1'b0;
                            r_corr_start   <= 1'b1;
                            r_state        <= S_ISSUE;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gps_ack_sched.sv
// Scoreboard bench for gps_ack_sched: random correlator responses, reference
// model of the search, decoupled monitors for corr_start, results and done.
module tb_gps_ack_sched;

    localparam int NUM   = 40;
    localparam int STEP  = 4;
    localparam int INIT  = -80;
    localparam int WDOG  = 20;
    localparam int STALL = 50;

    typedef struct {
        logic [5:0]         sat;
        logic signed [15:0] dop;
    } start_t;

    typedef struct {
        logic [5:0]         sat;
        logic [9:0]         cp;
        logic signed [15:0] dop;
        logic [13:0]        mag;
        logic               found;
        logic               tmo;
    } res_t;

    typedef struct {
        bit invalid;
        int cyc;
    } done_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               search_start;
    logic               abort;
    logic [5:0]         sat_first;
    logic [5:0]         sat_last;
    logic [13:0]        threshold;
    logic               busy;
    logic               search_done;
    logic               corr_start;
    logic [5:0]         corr_sat;
    logic signed [15:0] corr_doppler;
    logic               corr_done;
    logic [9:0]         corr_code_phase;
    logic [13:0]        corr_mag;
    logic               res_valid;
    logic               res_ready;
    logic [5:0]         res_sat;
    logic [9:0]         res_code_phase;
    logic signed [15:0] res_doppler;
    logic [13:0]        res_mag;
    logic               res_found;
    logic               res_timeout;

    gps_ack_sched #(.WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .search_start(search_start), .abort(abort),
        .sat_first(sat_first), .sat_last(sat_last), .threshold(threshold),
        .busy(busy), .search_done(search_done), .corr_start(corr_start),
        .corr_sat(corr_sat), .corr_doppler(corr_doppler), .corr_done(corr_done),
        .corr_code_phase(corr_code_phase), .corr_mag(corr_mag),
        .res_valid(res_valid), .res_ready(res_ready), .res_sat(res_sat),
        .res_code_phase(res_code_phase), .res_doppler(res_doppler),
        .res_mag(res_mag), .res_found(res_found), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Correlator behaviour per (PRN, bin)
    int mag_t [64][NUM];
    int cp_t  [64][NUM];
    int lat_t [64][NUM];
    bit sil_t [64][NUM];

    start_t q_start[$];
    res_t   q_res[$];
    done_t  q_done[$];

    int n_chk = 0;
    int n_fail = 0;
    int n_starts = 0;
    int last_hs = -100;
    int vcnt = 0;
    int rdy_mode = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string msg);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    function automatic int bin_of(input logic signed [15:0] d);
        int off;
        off = int'(d) - INIT;
        if (off < 0 || (off % STEP) != 0 || off / STEP >= NUM) return -1;
        return off / STEP;
    endfunction

    // Correlator model
    initial begin
        int s;
        int b;
        corr_done = 1'b0;
        corr_mag = 14'd0;
        corr_code_phase = 10'd0;
        forever begin
            @(negedge clk);
            if (corr_start) begin
                s = int'(corr_sat);
                b = bin_of(corr_doppler);
                if (b >= 0 && !sil_t[s][b]) begin
                    repeat (lat_t[s][b]) @(posedge clk);
                    #1;
                    corr_done = 1'b1;
                    corr_mag = 14'(mag_t[s][b]);
                    corr_code_phase = 10'(cp_t[s][b]);
                    @(posedge clk);
                    #1;
                    corr_done = 1'b0;
                    corr_mag = 14'($urandom);
                    corr_code_phase = 10'($urandom);
                end
            end
        end
    end

    // corr_start monitor: sequence, bin-to-bin spacing, no start while a result waits
    initial begin
        start_t e;
        int b;
        int pv_sat = -1;
        int pv_bin = -1;
        int pv_cyc = 0;
        forever begin
            @(negedge clk);
            if (corr_start) begin
                n_starts++;
                chk("start_during_result", res_valid, 0);
                if (q_start.size() == 0) begin
                    fail_now($sformatf("unexpected_corr_start sat %0d doppler %0d", corr_sat, corr_doppler));
                end else begin
                    e = q_start.pop_front();
                    chk("corr_sat", corr_sat, e.sat);
                    chk("corr_doppler", corr_doppler, e.dop);
                end
                b = bin_of(corr_doppler);
                if (b >= 1 && int'(corr_sat) == pv_sat && b == pv_bin + 1)
                    chk("bin_gap", cyc - pv_cyc,
                        sil_t[pv_sat][pv_bin] ? WDOG + 2 : lat_t[pv_sat][pv_bin] + 1);
                pv_sat = int'(corr_sat);
                pv_bin = b;
                pv_cyc = cyc;
            end
        end
    end

    // Result monitor: every presented cycle must match the expected head
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (res_valid) begin
                if (q_res.size() == 0) begin
                    fail_now($sformatf("unexpected_result sat %0d", res_sat));
                end else begin
                    e = q_res[0];
                    chk("res_sat", res_sat, e.sat);
                    chk("res_code_phase", res_code_phase, e.cp);
                    chk("res_doppler", res_doppler, e.dop);
                    chk("res_mag", res_mag, e.mag);
                    chk("res_found", res_found, e.found);
                    chk("res_timeout", res_timeout, e.tmo);
                    if (res_ready) begin
                        void'(q_res.pop_front());
                        last_hs = cyc;
                        vcnt = 0;
                    end else begin
                        vcnt++;
                    end
                end
            end
        end
    end

    // search_done monitor
    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            if (search_done) begin
                if (q_done.size() == 0) begin
                    fail_now("unexpected_search_done");
                end else begin
                    d = q_done.pop_front();
                    chk("search_done_cycle", cyc, d.invalid ? d.cyc + 1 : last_hs + 1);
                    chk("busy_at_done", busy, 0);
                end
            end
        end
    end

    // Consumer ready
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ($urandom_range(0, 2) != 0);
                default: res_ready = (vcnt >= STALL);
            endcase
        end
    end

    task automatic fill_rand(input int s, input int sil_pct);
        for (int b = 0; b < NUM; b++) begin
            mag_t[s][b] = $urandom_range(1, 16383);
            cp_t[s][b]  = $urandom_range(0, 1023);
            lat_t[s][b] = $urandom_range(1, 5);
            sil_t[s][b] = ($urandom_range(0, 99) < sil_pct);
        end
    endtask

    // Reference: one sweep per PRN, first strictly-largest magnitude wins
    task automatic model_push(input int first, input int last, input int thr);
        res_t r;
        int bm;
        for (int s = first; s <= last; s++) begin
            bm = 0;
            r.sat = 6'(s);
            r.cp = 10'd0;
            r.dop = 16'sd0;
            r.tmo = 1'b0;
            for (int b = 0; b < NUM; b++) begin
                q_start.push_back('{6'(s), 16'(INIT + STEP * b)});
                if (sil_t[s][b]) begin
                    r.tmo = 1'b1;
                end else if (mag_t[s][b] > bm) begin
                    bm = mag_t[s][b];
                    r.cp = 10'(cp_t[s][b]);
                    r.dop = 16'(INIT + STEP * b);
                end
            end
            r.mag = 14'(bm);
            r.found = (bm >= thr);
            q_res.push_back(r);
        end
        q_done.push_back('{1'b0, 0});
    endtask

    task automatic issue(input int first, input int last, input bit valid);
        @(posedge clk);
        #1;
        if (!valid) q_done.push_back('{1'b1, cyc});
        sat_first = 6'(first);
        sat_last = 6'(last);
        search_start = 1'b1;
        @(posedge clk);
        #1;
        search_start = 1'b0;
        chk("busy_after_start", busy, valid);
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        while ((q_start.size() != 0 || q_res.size() != 0 || q_done.size() != 0 || busy) && g < 20000) begin
            @(posedge clk);
            g++;
        end
        if (g >= 20000) fail_now({"timeout_", nm});
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_search_done"}, search_done, 0);
        chk({nm, "_corr_start"}, corr_start, 0);
        chk({nm, "_corr_sat"}, corr_sat, 0);
        chk({nm, "_corr_doppler"}, corr_doppler, INIT);
        chk({nm, "_res_valid"}, res_valid, 0);
        chk({nm, "_res_found"}, res_found, 0);
        chk({nm, "_res_timeout"}, res_timeout, 0);
        chk({nm, "_res_sat"}, res_sat, 0);
        chk({nm, "_res_cp"}, res_code_phase, 0);
        chk({nm, "_res_doppler"}, res_doppler, 0);
        chk({nm, "_res_mag"}, res_mag, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int f;
        int l;
        int thr;
        int base;
        int g;
        rst = 1'b1;
        search_start = 1'b0;
        abort = 1'b0;
        sat_first = 6'd0;
        sat_last = 6'd0;
        threshold = 14'd0;
        for (int s = 0; s < 64; s++) fill_rand(s, 0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Single PRN, peak on the zero-Doppler bin
        for (int b = 0; b < NUM; b++) begin
            mag_t[5][b] = (b == 20) ? 100 : 10;
            cp_t[5][b] = b + 3;
        end
        threshold = 14'd50;
        model_push(5, 5, 50);
        issue(5, 5, 1);
        wait_idle("single_prn");

        // Three PRNs with a long stall on every result
        rdy_mode = 2;
        for (int s = 1; s <= 3; s++) fill_rand(s, 0);
        threshold = 14'd8000;
        model_push(1, 3, 8000);
        issue(1, 3, 1);
        wait_idle("stall");
        rdy_mode = 0;

        // Equal peaks: earlier bin kept; found boundary at the threshold
        for (int b = 0; b < NUM; b++) mag_t[7][b] = $urandom_range(1, 60);
        mag_t[7][3] = 70;
        mag_t[7][9] = 70;
        cp_t[7][3] = 111;
        cp_t[7][9] = 222;
        for (int k = 0; k < 2; k++) begin
            thr = 70 + k;
            threshold = 14'(thr);
            model_push(7, 7, thr);
            issue(7, 7, 1);
            wait_idle("tie");
        end

        // Silent correlator on bin 0 of one PRN
        fill_rand(2, 0);
        sil_t[2][0] = 1'b1;
        threshold = 14'd300;
        model_push(2, 2, 300);
        issue(2, 2, 1);
        wait_idle("watchdog");

        // Random ranges with occasional silent bins; a start while busy is ignored
        rdy_mode = 1;
        for (int k = 0; k < 4; k++) begin
            f = $urandom_range(1, 30);
            l = f + $urandom_range(0, 2);
            for (int s = f; s <= l; s++) fill_rand(s, 3);
            thr = $urandom_range(0, 16383);
            threshold = 14'(thr);
            model_push(f, l, thr);
            issue(f, l, 1);
            repeat (30) @(posedge clk);
            #1;
            sat_first = 6'd1;
            sat_last = 6'd32;
            search_start = 1'b1;
            @(posedge clk);
            #1;
            search_start = 1'b0;
            wait_idle("random");
        end
        rdy_mode = 0;

        // Abort in the wait of bin 7; its late completion must be ignored
        fill_rand(11, 0);
        lat_t[11][7] = 5;
        for (int b = 0; b <= 7; b++) q_start.push_back('{6'd11, 16'(INIT + STEP * b)});
        base = n_starts;
        issue(11, 11, 1);
        g = 0;
        while (n_starts < base + 8 && g < 2000) begin
            @(posedge clk);
            g++;
        end
        if (g >= 2000) fail_now("timeout_abort_wait");
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_corr_start", corr_start, 0);
        chk("abort_res_valid", res_valid, 0);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_pending_starts", q_start.size(), 0);
        chk("abort_busy_later", busy, 0);
        fill_rand(12, 0);
        threshold = 14'd1000;
        model_push(12, 12, 1000);
        issue(12, 12, 1);
        wait_idle("after_abort");

        // Invalid ranges
        issue(9, 4, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("bad_range_busy", busy, 0);
        issue(0, 3, 0);
        wait_idle("bad_range");

        // Reset in the middle of a sweep
        for (int s = 20; s <= 21; s++) fill_rand(s, 0);
        threshold = 14'd0;
        model_push(20, 21, 0);
        issue(20, 21, 1);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("mid_reset");
        q_start.delete();
        q_res.delete();
        q_done.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        fill_rand(3, 0);
        threshold = 14'd4000;
        model_push(3, 3, 4000);
        issue(3, 3, 1);
        wait_idle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
